// File: rtl/calc_pkg.sv
// Shared definitions for the streaming calculator core: op codes, FSM states
// and flag bit positions.
package calc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_XNOR = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ASR  = 4'd10,
    OP_ROL  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_SEND   = 2'd3
  } state_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  localparam logic [3:0] ILLEGAL_OP_MIN = 4'd12;

endpackage

// File: rtl/alu_param.sv
// Combinational WIDTH-bit ALU producing the result, {V,C,N,Z} flags and an
// illegal-op indication.
module alu_param
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int unsigned SW = $clog2(WIDTH);

  logic [SW-1:0]      amt;
  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] rot;
  logic               carry;
  logic               ovf;

  assign amt = b[SW-1:0];

  // Shifts run on WIDTH+1 bits so the last bit shifted out lands in the spare bit.
  always_comb begin
    y       = '0;
    ext     = '0;
    rot     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    flags   = '0;
    if (op >= ILLEGAL_OP_MIN) begin
      illegal = 1'b1;
    end else begin
      case (op)
        OP_ADD: begin
          ext   = {1'b0, a} + {1'b0, b};
          y     = ext[WIDTH-1:0];
          carry = ext[WIDTH];
          ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          ext   = {1'b0, a} - {1'b0, b};
          y     = ext[WIDTH-1:0];
          carry = ext[WIDTH];
          ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND:  y = a & b;
        OP_OR:   y = a | b;
        OP_XOR:  y = a ^ b;
        OP_NAND: y = ~(a & b);
        OP_NOR:  y = ~(a | b);
        OP_XNOR: y = ~(a ^ b);
        OP_SHL: begin
          ext   = {1'b0, a} << amt;
          y     = ext[WIDTH-1:0];
          carry = ext[WIDTH];
        end
        OP_SHR: begin
          ext   = {a, 1'b0} >> amt;
          y     = ext[WIDTH:1];
          carry = ext[0];
        end
        OP_ASR: begin
          ext   = $signed({a, 1'b0}) >>> amt;
          y     = ext[WIDTH:1];
          carry = ext[0];
        end
        OP_ROL: begin
          rot = {a, a} << amt;
          y   = rot[2*WIDTH-1:WIDTH];
        end
        default: ;
      endcase
      flags[FLAG_Z] = (y == '0);
      flags[FLAG_N] = y[WIDTH-1];
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/calc_stream_core.sv
// Byte-streamed calculator: loads A and B LSB first, executes one ALU op,
// then streams the result back with valid/ready back-pressure.
module calc_stream_core
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] op,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] flags,
  output logic       err,
  output logic       busy
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned IW = $clog2(NB) + 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  state_e           state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [IW+2:0]    ofs;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] byte_mask, byte_in;
  logic [3:0]       flags_d;
  logic             err_d, in_ready_d, out_valid_d, busy_d;
  logic [7:0]       out_data_d;
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_flags;
  logic             alu_illegal;
  logic             in_fire, out_fire;

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .y       (alu_y),
    .flags   (alu_flags),
    .illegal (alu_illegal)
  );

  assign ofs       = {idx, 3'b000};
  assign byte_mask = WIDTH'(8'hFF) << ofs;
  assign byte_in   = WIDTH'(in_data) << ofs;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state logic; outputs are registered from the next state.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags;
    err_d   = err;
    case (state)
      ST_LOAD_A: begin
        if (in_fire) begin
          a_d = (a_q & ~byte_mask) | byte_in;
          if (idx == '0) op_d = op;
          if (idx == LAST) begin
            state_d = ST_LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (in_fire) begin
          b_d = (b_q & ~byte_mask) | byte_in;
          if (idx == LAST) begin
            state_d = ST_EXEC;
            idx_d   = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      ST_EXEC: begin
        res_d   = alu_y;
        flags_d = alu_flags;
        err_d   = alu_illegal;
        state_d = ST_SEND;
        idx_d   = '0;
      end
      ST_SEND: begin
        if (out_fire) begin
          if (idx == LAST) begin
            state_d = ST_LOAD_A;
            idx_d   = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      default: state_d = ST_LOAD_A;
    endcase

    in_ready_d  = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    out_valid_d = (state_d == ST_SEND);
    out_data_d  = out_valid_d ? 8'(res_d >> {idx_d, 3'b000}) : 8'h00;
    busy_d      = (state_d != ST_LOAD_A) || (idx_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD_A;
      idx       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flags     <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      flags     <= flags_d;
      err       <= err_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_stream_core.sv
// Self-checking bench for calc_stream_core at WIDTH=16: directed vector table,
// back-pressure / reset sequences and randomized transactions against a model.
module tb_calc_stream_core;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NB    = WIDTH / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] flags;
  logic       err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic [3:0]  f;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  calc_stream_core #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flags     (flags),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result and {V,C,N,Z} derived with integer arithmetic on values.
  function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] y, output logic [3:0] f, output logic e);
    int ua  = int'(a);
    int ub  = int'(b);
    int sa  = int'($signed(a));
    int sb  = int'($signed(b));
    int amt = int'(b) % 16;
    int r   = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    e = 1'b0;
    case (o)
      4'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1: begin r = ua - ub; c = (ua < ub);   v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ~(ua & ub);
      4'd6: r = ~(ua | ub);
      4'd7: r = ~(ua ^ ub);
      4'd8: begin r = ua << amt; c = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0); end
      4'd9: begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      4'd10: begin r = sa >>> amt; c = (amt != 0) && (((sa >>> (amt - 1)) & 1) != 0); end
      4'd11: r = (ua << amt) | (ua >> (16 - amt));
      default: begin r = 0; e = 1'b1; end
    endcase
    y = 16'(r);
    f = e ? 4'h0 : {v, c, y[15], (y == 16'h0)};
  endfunction

  task automatic push_byte(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_ops(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o;
    for (int i = 0; i < NB; i++) begin
      push_byte(a[8*i +: 8]);
      op = 4'($urandom);
    end
    for (int i = 0; i < NB; i++) push_byte(b[8*i +: 8]);
  endtask

  task automatic run_txn(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input int stall_pct, output logic [15:0] y, output logic [3:0] f,
                         output logic e, output int lat);
    y = '0; f = '0; e = 1'b0; lat = 0;
    load_ops(o, a, b);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < NB; i++) begin
      int n = 0;
      bit done = 1'b0;
      while (!done && n < 100) begin
        out_ready = ($urandom_range(99) >= stall_pct);
        if (out_valid && out_ready) begin
          y[8*i +: 8] = out_data;
          if (i == 0) begin f = flags; e = err; end
          done = 1'b1;
        end
        @(posedge clk); #1;
        n++;
      end
      if (!done) check("out_wait", 32'(done), 32'd1);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] y, my;
    logic [3:0]  f, mf;
    logic        e, me;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; op = 4'h0; out_ready = 1'b0;

    vecs.push_back('{4'd0,  16'h1234, 16'h0FCD, 16'h2201, 4'b0000, 1'b0});
    vecs.push_back('{4'd1,  16'h0001, 16'h0002, 16'hFFFF, 4'b0110, 1'b0});
    vecs.push_back('{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1'b0});
    vecs.push_back('{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1'b0});
    vecs.push_back('{4'd8,  16'h8421, 16'h0004, 16'h4210, 4'b0000, 1'b0});
    vecs.push_back('{4'd13, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1});
    vecs.push_back('{4'd4,  16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000, 1'b0});
    vecs.push_back('{4'd9,  16'h0003, 16'h0001, 16'h0001, 4'b0100, 1'b0});
    vecs.push_back('{4'd10, 16'h8001, 16'h0001, 16'hC000, 4'b0110, 1'b0});
    vecs.push_back('{4'd11, 16'h8001, 16'h0001, 16'h0003, 4'b0000, 1'b0});
    vecs.push_back('{4'd5,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001, 1'b0});
    vecs.push_back('{4'd8,  16'h8000, 16'h0010, 16'h8000, 4'b0010, 1'b0});
    vecs.push_back('{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 1'b0});
    vecs.push_back('{4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 4'b0010, 1'b0});
    vecs.push_back('{4'd3,  16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0});
    vecs.push_back('{4'd6,  16'h0000, 16'h0000, 16'hFFFF, 4'b0010, 1'b0});
    vecs.push_back('{4'd7,  16'h1234, 16'h1234, 16'hFFFF, 4'b0010, 1'b0});
    vecs.push_back('{4'd10, 16'h4000, 16'h000F, 16'h0000, 4'b0101, 1'b0});
    vecs.push_back('{4'd9,  16'h8000, 16'h000F, 16'h0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd8,  16'h0001, 16'h000F, 16'h8000, 4'b0010, 1'b0});
    vecs.push_back('{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1'b1});

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'h0);
    check("reset_flags",     32'(flags),     32'h0);
    check("reset_err",       32'(err),       32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    rst = 1'b0;

    // Directed vector table, no back-pressure.
    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, 0, y, f, e, lat);
      check($sformatf("vec%0d_result", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d_flags", i),  32'(f), 32'(vecs[i].f));
      check($sformatf("vec%0d_err", i),    32'(e), 32'(vecs[i].e));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
    end

    // Back-pressure on the first result byte; in_valid must be ignored meanwhile.
    op = 4'd8;
    push_byte(8'h21);
    check("busy_after_first_byte", 32'(busy), 32'd1);
    op = 4'd0;
    push_byte(8'h84);
    push_byte(8'h04);
    push_byte(8'h00);
    @(posedge clk); #1;
    check("stall_out_valid_up", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_out_data", c), 32'(out_data), 32'h10);
      check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d_out_valid", c), 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_byte0", 32'(out_data), 32'h10);
    @(posedge clk); #1;
    check("stall_byte1", 32'(out_data), 32'h42);
    check("stall_flags", 32'(flags), 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_done_out_valid", 32'(out_valid), 32'd0);
    check("stall_done_in_ready",  32'(in_ready),  32'd1);
    check("stall_done_busy",      32'(busy),      32'd0);

    // Mid-transaction reset after 3 accepted bytes.
    run_txn(4'd1, 16'h0001, 16'h0002, 0, y, f, e, lat);
    check("pre_reset_flags", 32'(flags), 32'h6);
    op = 4'd1;
    push_byte(8'hFF);
    push_byte(8'hFF);
    push_byte(8'hFF);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_reset_busy",      32'(busy),      32'd0);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check("post_reset_flags",     32'(flags),     32'h0);
    check("post_reset_in_ready",  32'(in_ready),  32'd1);
    run_txn(4'd0, 16'h0002, 16'h0003, 0, y, f, e, lat);
    check("post_reset_add", 32'(y), 32'h0005);
    check("post_reset_add_flags", 32'(f), 32'h0);

    // Randomized transactions with random back-pressure.
    for (int t = 0; t < 150; t++) begin
      logic [3:0]  ro;
      logic [15:0] ra, rb;
      ro = 4'($urandom_range(15));
      ra = 16'($urandom);
      rb = (t % 3 == 0) ? 16'($urandom_range(15)) : 16'($urandom);
      model(ro, ra, rb, my, mf, me);
      run_txn(ro, ra, rb, 30, y, f, e, lat);
      check($sformatf("rand%0d_op%0d_result", t, ro), 32'(y), 32'(my));
      check($sformatf("rand%0d_op%0d_flags", t, ro),  32'(f), 32'(mf));
      check($sformatf("rand%0d_op%0d_err", t, ro),    32'(e), 32'(me));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
